// File: rtl/ssp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_pkg
//  Description : Definitions shared by the SSP transmit and receive logic:
//                the serializer state encoding and the default frame width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssp_pkg;

    // Default serial frame length. It must match the FIFO word width.
    localparam int SSP_DATA_WIDTH = 8;

    // Serializer states.
    //   ST_IDLE  : line quiet, waiting for data in the TX FIFO
    //   ST_FRAME : frame-sync period ahead of the MSB
    //   ST_SHIFT : data bits are being driven
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_SHIFT = 2'd2
    } ssp_state_t;

endpackage : ssp_pkg
`default_nettype wire

// File: rtl/ssp_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_clk_gen
//  Description : Serial clock generator. Produces SSPCLKOUT at clk/2 and the
//                edge strobes used by the serializer.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                sclk - serial clock output (toggles on every clk edge)
//                tick - high when the next clk edge drives sclk 0->1
//                fall - high when the next clk edge drives sclk 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module ssp_clk_gen (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic tick,
    output logic fall
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk <= 1'b0;
        end else begin
            sclk <= ~sclk;
        end
    end

    // The strobes describe the edge that is about to happen, so logic in the
    // same clock domain can act on "this edge is a tick" directly.
    assign tick = ~sclk;
    assign fall = sclk;

endmodule : ssp_clk_gen
`default_nettype wire

// File: rtl/tx_logic.sv
`default_nettype none
// ============================================================================
//  Module      : tx_logic
//  Description : SSP transmit serializer. Pops words from the TX FIFO and
//                shifts them out MSB-first with a one-period frame sync ahead
//                of each word. Back-to-back words are sent without gaps.
//  Ports       : PCLK          - system clock
//                CLEAR         - asynchronous active-high reset
//                tx_fifo_empty - TX FIFO has no data
//                TxData        - TX FIFO head word (show-ahead)
//                read_fifo     - single-cycle pop strobe to the TX FIFO
//                SSPCLKOUT     - serial clock, PCLK/2
//                SSPFSSOUT     - frame sync, one serial period before the MSB
//                SSPTXD        - serial data, MSB first
//                SSPOE_B       - active-low pad output enable
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_logic
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic                  tx_fifo_empty,
    input  logic [DATA_WIDTH-1:0] TxData,
    output logic                  read_fifo,
    output logic                  SSPCLKOUT,
    output logic                  SSPFSSOUT,
    output logic                  SSPTXD,
    output logic                  SSPOE_B
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Count value while the LSB is on the line, and the value one bit earlier.
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_PEN_CNT  = CNT_W'(DATA_WIDTH - 2);

    ssp_state_t            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_tick;
    logic                  w_fall;
    logic                  w_load;

    ssp_clk_gen u_clk_gen (
        .clk  (PCLK),
        .rst  (CLEAR),
        .sclk (SSPCLKOUT),
        .tick (w_tick),
        .fall (w_fall)
    );

    // A new word is loaded either at the end of the frame-sync period, or at
    // the end of an LSB period during which frame sync was raised because
    // more data was already waiting (continuous mode).
    assign w_load = w_tick &&
                    ((r_state == ST_FRAME) ||
                     ((r_state == ST_SHIFT) && (r_count == C_LAST_CNT) && SSPFSSOUT));

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            read_fifo <= 1'b0;
            SSPFSSOUT <= 1'b0;
            SSPTXD    <= 1'b0;
            SSPOE_B   <= 1'b1;
        end else begin
            read_fifo <= 1'b0;

            // Output enable moves on falls only: it opens half a period into
            // the frame-sync period and closes half a period after the last
            // LSB. During continuous mode the state never returns to idle, so
            // the pad stays enabled across word boundaries.
            if (w_fall) begin
                if (SSPFSSOUT) begin
                    SSPOE_B <= 1'b0;
                end else if (r_state == ST_IDLE) begin
                    SSPOE_B <= 1'b1;
                end
            end

            if (w_load) begin
                // The head word is consumed here; the FIFO pops on the
                // following fall edge while read_fifo is high.
                SSPFSSOUT <= 1'b0;
                SSPTXD    <= TxData[DATA_WIDTH-1];
                r_shift   <= TxData << 1;
                r_count   <= '0;
                read_fifo <= 1'b1;
                r_state   <= ST_SHIFT;
            end else if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        SSPTXD <= 1'b0;
                        if (!tx_fifo_empty) begin
                            SSPFSSOUT <= 1'b1;
                            r_state   <= ST_FRAME;
                        end
                    end

                    ST_SHIFT: begin
                        if (r_count == C_LAST_CNT) begin
                            // LSB period over with nothing queued behind it.
                            SSPTXD  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            SSPTXD  <= r_shift[DATA_WIDTH-1];
                            r_shift <= r_shift << 1;
                            r_count <= r_count + 1'b1;
                            // Driving the LSB now: announce the next word so
                            // its frame sync overlaps this LSB period.
                            if ((r_count == C_PEN_CNT) && !tx_fifo_empty) begin
                                SSPFSSOUT <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : tx_logic
`default_nettype wire

// File: tb/tb_tx_logic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_logic
//  Description : Self-checking bench for tx_logic. A FIFO model feeds the
//                serializer and a receiver model recovers words from the
//                serial lines; per-test results are compared to a table of
//                hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_logic;

    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          CLEAR = 1'b1;
    logic          tx_fifo_empty;
    logic [DW-1:0] TxData;
    logic          read_fifo;
    logic          SSPCLKOUT;
    logic          SSPFSSOUT;
    logic          SSPTXD;
    logic          SSPOE_B;

    tx_logic #(.DATA_WIDTH(DW)) dut (
        .PCLK          (PCLK),
        .CLEAR         (CLEAR),
        .tx_fifo_empty (tx_fifo_empty),
        .TxData        (TxData),
        .read_fifo     (read_fifo),
        .SSPCLKOUT     (SSPCLKOUT),
        .SSPFSSOUT     (SSPFSSOUT),
        .SSPTXD        (SSPTXD),
        .SSPOE_B       (SSPOE_B)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fifo_q[$];

    function automatic void fifo_outs();
        tx_fifo_empty = (fifo_q.size() == 0);
        TxData        = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endfunction

    task automatic push(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        fifo_outs();
    endtask

    // ---------------- receiver / protocol monitor ----------------
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] rx_sh;
    int bits_left, data_samples;
    int pops, fss_cnt, oe_low, oe_rises;
    int consec_err, oe_err, idle_txd_err;
    logic prev_rd = 1'b0;
    logic prev_oe = 1'b1;

    always @(negedge PCLK) begin
        if (CLEAR) begin
            bits_left = 0;
            prev_rd   = 1'b0;
            prev_oe   = 1'b1;
        end else begin
            if (read_fifo) begin
                pops++;
                if (prev_rd) consec_err++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                fifo_outs();
            end
            prev_rd = read_fifo;

            if (!SSPOE_B) oe_low++;
            if (SSPOE_B && !prev_oe) oe_rises++;
            prev_oe = SSPOE_B;

            // One sample per serial period, between a tick and the next fall.
            if (SSPCLKOUT) begin
                if (bits_left > 0) begin
                    rx_sh = {rx_sh[DW-2:0], SSPTXD};
                    bits_left--;
                    data_samples++;
                    if (SSPOE_B) oe_err++;
                    if (bits_left == 0) rx_q.push_back(rx_sh);
                end else if (!SSPFSSOUT && SSPTXD) begin
                    idle_txd_err++;
                end
                if (SSPFSSOUT) begin
                    fss_cnt++;
                    bits_left = DW;
                end
            end
        end
    end

    // Assert reset mid-cycle, check reset outputs, clear all bench state.
    task automatic enter_reset();
        @(negedge PCLK);
        #2 CLEAR = 1'b1;
        #1;
        check("rst_sclk", 32'(SSPCLKOUT), 32'd0);
        check("rst_fss",  32'(SSPFSSOUT), 32'd0);
        check("rst_txd",  32'(SSPTXD),    32'd0);
        check("rst_oe_b", 32'(SSPOE_B),   32'd1);
        check("rst_rd",   32'(read_fifo), 32'd0);
        fifo_q.delete();
        fifo_outs();
        rx_q.delete();
        data_samples = 0; pops = 0; fss_cnt = 0; oe_low = 0; oe_rises = 0;
        consec_err = 0; oe_err = 0; idle_txd_err = 0;
    endtask

    task automatic release_reset();
        @(negedge PCLK);
        CLEAR = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] d [4];
        int            n;
        bit            late;       // second word arrives only after the first LSB
        int            exp_pops;
        int            exp_fss;
        int            exp_oe_low; // PCLK cycles with SSPOE_B low
        int            exp_oe_rises;
    } vec_t;

    vec_t vt [4];

    initial begin
        int lat;
        int toggles;
        logic prev_sclk;
        bit   done;

        vt[0] = '{d: '{8'hA5, 8'h00, 8'h00, 8'h00}, n: 1, late: 0,
                  exp_pops: 1, exp_fss: 1, exp_oe_low: 18, exp_oe_rises: 1};
        vt[1] = '{d: '{8'h3C, 8'hC3, 8'h00, 8'h00}, n: 2, late: 0,
                  exp_pops: 2, exp_fss: 2, exp_oe_low: 34, exp_oe_rises: 1};
        vt[2] = '{d: '{8'h00, 8'hFF, 8'h5A, 8'h96}, n: 4, late: 0,
                  exp_pops: 4, exp_fss: 4, exp_oe_low: 66, exp_oe_rises: 1};
        vt[3] = '{d: '{8'h01, 8'h02, 8'h00, 8'h00}, n: 2, late: 1,
                  exp_pops: 2, exp_fss: 2, exp_oe_low: 36, exp_oe_rises: 2};

        fifo_outs();

        // ---- empty FIFO: clock runs, everything else idle ----
        enter_reset();
        release_reset();
        prev_sclk = SSPCLKOUT;
        toggles = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge PCLK);
            if (SSPCLKOUT != prev_sclk) toggles++;
            prev_sclk = SSPCLKOUT;
        end
        check("empty_toggles", 32'(toggles), 32'd50);
        check("empty_fss",     32'(fss_cnt), 32'd0);
        check("empty_pops",    32'(pops),    32'd0);
        check("empty_oe_low",  32'(oe_low),  32'd0);
        check("empty_txd",     32'(idle_txd_err), 32'd0);

        // ---- table-driven frames ----
        for (int v = 0; v < 4; v++) begin
            enter_reset();
            push(vt[v].d[0]);
            if (!vt[v].late) begin
                for (int i = 1; i < vt[v].n; i++) push(vt[v].d[i]);
            end
            release_reset();

            lat = 0;
            while (!read_fifo && lat < 8) begin
                @(negedge PCLK);
                lat++;
            end
            check("pop_latency_ok", 32'(lat <= 4), 32'd1);

            done = 0;
            for (int k = 0; k < 600 && !done; k++) begin
                @(negedge PCLK);
                if (vt[v].late && data_samples >= DW && fifo_q.size() == 0 && pops == 1)
                    push(vt[v].d[1]);
                if (rx_q.size() >= vt[v].n) done = 1;
            end
            check("frame_timeout", 32'(done), 32'd1);
            repeat (6) @(negedge PCLK);

            check("rx_count", 32'(rx_q.size()), 32'(vt[v].n));
            for (int i = 0; i < vt[v].n; i++) begin
                if (i < rx_q.size()) check("rx_byte", 32'(rx_q[i]), 32'(vt[v].d[i]));
            end
            check("pops",       32'(pops),        32'(vt[v].exp_pops));
            check("fss_periods",32'(fss_cnt),     32'(vt[v].exp_fss));
            check("oe_low",     32'(oe_low),      32'(vt[v].exp_oe_low));
            check("oe_rises",   32'(oe_rises),    32'(vt[v].exp_oe_rises));
            check("rd_consec",  32'(consec_err),  32'd0);
            check("oe_in_data", 32'(oe_err),      32'd0);
            check("idle_txd",   32'(idle_txd_err),32'd0);
            check("end_oe_b",   32'(SSPOE_B),     32'd1);
            check("end_txd",    32'(SSPTXD),      32'd0);
        end

        // ---- reset mid-frame, then a clean restart ----
        enter_reset();
        push(8'hFF);
        release_reset();
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge PCLK);
            if (data_samples >= 3) done = 1;
        end
        check("midrst_reach", 32'(done), 32'd1);
        enter_reset();
        push(8'h81);
        release_reset();
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge PCLK);
            if (rx_q.size() >= 1) done = 1;
        end
        check("midrst_timeout", 32'(done), 32'd1);
        repeat (6) @(negedge PCLK);
        check("midrst_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() >= 1) check("midrst_byte", 32'(rx_q[0]), 32'h81);
        check("midrst_fss",  32'(fss_cnt), 32'd1);
        check("midrst_pops", 32'(pops),    32'd1);
        check("midrst_oe",   32'(oe_low),  32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tx_logic
`default_nettype wire
